// File: rtl/poly_arith_pkg.sv
// poly_arith_pkg: modulus, coefficient width, mod-Q helpers and controller state encoding
package poly_arith_pkg;
    localparam int Q = 8380417;
    localparam int CW = 23;
    localparam logic [CW:0] QW = (CW+1)'(Q);
    typedef enum logic [1:0] {IDLE, LOAD, ACC, DRAIN} state_t;
    function automatic logic [CW-1:0] normalise(input logic [31:0] x);
        return CW'(x[31] ? x + 32'(Q) : x);
    endfunction
    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return CW'(s >= QW ? s - QW : s);
    endfunction
    function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] d;
        d = {1'b0, a} - {1'b0, b};
        return CW'(d[CW] ? d + QW : d);
    endfunction
endpackage

// File: rtl/poly_acc_lane.sv
// poly_acc_lane: per-lane S2 registers (normalised input, old RAM word) and S3 fold arithmetic
module poly_acc_lane
    import poly_arith_pkg::*;
#(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic [IW-1:0] x,
    input  logic [CW-1:0] old,
    input  logic          load,
    input  logic          sub,
    output logic [CW-1:0] res
);
    logic [CW-1:0] norm_q, old_q;
    always_ff @(posedge clk) begin
        norm_q <= normalise(32'(signed'(x)));
        old_q  <= old;
    end
    assign res = load ? norm_q : sub ? mod_sub(old_q, norm_q) : mod_add(old_q, norm_q);
endmodule

// File: rtl/poly_vec_addsub_ctrl.sv
// poly_vec_addsub_ctrl: folds K streamed polynomials mod Q into an accumulator RAM, then drains the result
module poly_vec_addsub_ctrl
    import poly_arith_pkg::*;
#(
    parameter int N = 256,
    parameter int LANES = 2,
    parameter int IW = 32,
    parameter int MAX_K = 8,
    localparam int KW = $clog2(MAX_K + 1),
    localparam int BEATS = N / LANES,
    localparam int BW = $clog2(BEATS),
    localparam int DW = LANES * IW,
    localparam int RW = LANES * CW
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            start,
    input  logic            op_sub,
    input  logic [KW-1:0]   vec_len,
    input  logic            Read_FIFO_tvalid,
    output logic            Read_FIFO_tready,
    input  logic [DW-1:0]   Read_FIFO_tdata,
    input  logic            Read_FIFO_tlast,
    output logic            Write_FIFO_tvalid,
    input  logic            Write_FIFO_tready,
    output logic [DW-1:0]   Write_FIFO_tdata,
    output logic [DW/8-1:0] Write_FIFO_tkeep,
    output logic            Write_FIFO_tlast,
    output logic            busy,
    output logic            done,
    output logic            err
);
    state_t state, state_n;
    logic sub_q, in_done, in_hs, out_hs, wrap, last_poly, start_ok, rd_issue;
    logic [KW-1:0] k_q, poly_idx;
    logic [BW-1:0] beat_idx, s1_addr, s2_addr;
    logic [1:0] fl_cnt, cnt;
    logic [2:0] occ;
    logic s1_v, s1_load, s2_v, s2_load, rd_v, rd_last, rd_all, wptr, rptr;
    logic [DW-1:0] s1_data;
    logic [RW-1:0] ram [BEATS];
    logic [RW-1:0] rd_q, s3_word;
    logic [RW-1:0] bufd [2];
    logic lst [2];

    assign Read_FIFO_tready = (state == LOAD || state == ACC) && !in_done;
    assign in_hs = Read_FIFO_tready && Read_FIFO_tvalid;
    assign wrap = beat_idx == BW'(BEATS - 1);
    assign last_poly = poly_idx == k_q - 1'b1;
    assign start_ok = start && state == IDLE && vec_len != '0 && vec_len <= KW'(MAX_K);
    assign Write_FIFO_tvalid = cnt != 2'd0;
    assign Write_FIFO_tlast = Write_FIFO_tvalid && lst[rptr];
    assign Write_FIFO_tkeep = '1;
    assign out_hs = Write_FIFO_tvalid && Write_FIFO_tready;
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        occ = 3'(cnt) + 3'(rd_v) - 3'(out_hs);
        rd_issue = state == DRAIN && !rd_all && occ < 3'd2;
        case (state)
            IDLE:    state_n = start_ok ? LOAD : IDLE;
            LOAD:    state_n = in_hs && wrap && !last_poly ? ACC : in_done && fl_cnt == 2'd2 ? DRAIN : LOAD;
            ACC:     state_n = in_done && fl_cnt == 2'd2 ? DRAIN : ACC;
            default: state_n = out_hs && Write_FIFO_tlast ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
            {sub_q, k_q, poly_idx, beat_idx, in_done, fl_cnt} <= '0;
            {s1_v, s1_load, s1_addr, s2_v, s2_load, s2_addr} <= '0;
            {rd_v, rd_last, rd_all, wptr, rptr, cnt, done, err} <= '0;
        end else begin
            state <= state_n;
            done <= (start && state == IDLE && !start_ok) || (out_hs && Write_FIFO_tlast);
            if (start && state == IDLE) begin
                err <= !start_ok;
                sub_q <= op_sub;
                k_q <= vec_len;
                {poly_idx, beat_idx, in_done, fl_cnt, rd_all} <= '0;
            end
            if (in_hs) begin
                beat_idx <= wrap ? '0 : beat_idx + 1'b1;
                if (Read_FIFO_tlast != wrap) err <= 1'b1;
                if (wrap && last_poly) in_done <= 1'b1;
                if (wrap && !last_poly) poly_idx <= poly_idx + 1'b1;
            end
            if (in_done && state != DRAIN) fl_cnt <= fl_cnt + 1'b1;
            s1_v <= in_hs;
            s1_load <= state == LOAD;
            s1_addr <= beat_idx;
            s2_v <= s1_v;
            s2_load <= s1_load;
            s2_addr <= s1_addr;
            // drain reads reuse beat_idx, which has wrapped back to 0 by DRAIN entry
            if (rd_issue) begin
                beat_idx <= wrap ? '0 : beat_idx + 1'b1;
                rd_all <= wrap;
            end
            rd_v <= rd_issue;
            rd_last <= rd_issue && wrap;
            if (rd_v) wptr <= ~wptr;
            if (out_hs) rptr <= ~rptr;
            cnt <= cnt + 2'(rd_v) - 2'(out_hs);
        end
    end

    always_ff @(posedge clk) begin
        s1_data <= Read_FIFO_tdata;
        if (s2_v) ram[s2_addr] <= s3_word;
        rd_q <= ram[beat_idx];
        if (rd_v) begin
            bufd[wptr] <= rd_q;
            lst[wptr] <= rd_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        poly_acc_lane #(.IW(IW)) u_lane (
            .clk (clk),
            .x   (s1_data[i*IW +: IW]),
            .old (rd_q[i*CW +: CW]),
            .load(s2_load),
            .sub (sub_q),
            .res (s3_word[i*CW +: CW])
        );
        assign Write_FIFO_tdata[i*IW +: IW] = IW'(bufd[rptr][i*CW +: CW]);
    end
endmodule

// File: doc/poly_vec_addsub_ctrl.md
Name: poly_vec_addsub_ctrl

Overview:
Parametrised successor to the single-mode polynomial add controller. It streams K polynomials of N coefficients in from the read FIFO, several lanes per beat, and folds them into an internal accumulator RAM modulo Q. In add mode it computes p0+p1+...+p(K-1); in sub mode it computes p0-p1-...-p(K-1). It then streams the result to the write FIFO with full backpressure and a correct tlast. It sits in the top-level control datapath beside the NTT/mul controllers, on the same AXI-Stream FIFO pair.

Parameters:
Q, 8380417, modulus; coefficients held in [0,Q)
CW, 23, coefficient width; must equal clog2(Q)
N, 256, coefficients per polynomial
LANES, 2, coefficients per stream beat; N/LANES must be >= 4
IW, 32, lane field width in stream data, signed two's complement
MAX_K, 8, maximum vector length

Ports:
clk  in  1  clock
areset  in  1  synchronous, active-high reset
start  in  1  one-cycle start pulse; ignored unless idle
op_sub  in  1  0 = add all, 1 = p0 minus the rest; sampled at start
vec_len  in  clog2(MAX_K+1)  K; sampled at start
Read_FIFO_tvalid  in  1  input beat valid
Read_FIFO_tready  out  1  input beat accepted
Read_FIFO_tdata  in  LANES*IW  lane i in bits [i*IW +: IW]
Read_FIFO_tlast  in  1  marks the last beat of a polynomial
Write_FIFO_tvalid  out  1  output beat valid
Write_FIFO_tready  in  1  downstream ready
Write_FIFO_tdata  out  LANES*IW  result lanes, zero-extended from CW
Write_FIFO_tkeep  out  LANES*IW/8  constant all-ones
Write_FIFO_tlast  out  1  asserted on the final output beat only
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final output handshake
err  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset (areset=1 at a clk edge): state IDLE; all counters cleared; all outputs 0 except Write_FIFO_tkeep. Reset mid-operation aborts the operation immediately; RAM contents are don't-care.
- BEATS = N/LANES. Counters: beat_idx 0..BEATS-1 and poly_idx 0..K-1.
- start while IDLE with 1<=vec_len<=MAX_K: latch op_sub and K; go to LOAD.
- start while IDLE with vec_len=0 or vec_len>MAX_K: set err, pulse done next cycle, stay IDLE.
- start while not IDLE: ignored.
- LOAD (poly 0) and ACC (polys 1..K-1):
  - Read_FIFO_tready=1; each handshake advances beat_idx.
  - Lane normalise: x<0 gives x+Q, otherwise x. Input range (-Q,Q) is a precondition.
  - Pipeline: S1 registers the beat and issues the RAM read at beat_idx. S2 normalises and captures the RAM word. S3 computes the result and writes the RAM.
  - LOAD writes the normalised value.
  - ACC add: s=a+b (CW+1 bits); s>=Q gives s-Q.
  - ACC sub: d=a-b; if d<0 then d+Q.
  - No read-after-write hazard, because the same address recurs only BEATS beats later and BEATS>=4 exceeds the pipeline depth.
  - Wrap of beat_idx from BEATS-1 to 0 increments poly_idx.
  - After the last beat of the last polynomial: tready=0, wait for the pipeline to empty (3 cycles), then go to DRAIN.
- tlast check: tlast asserted at beat_idx!=BEATS-1, or deasserted at beat_idx=BEATS-1, sets err. Beat counting remains authoritative; no resync.
- DRAIN:
  - RAM reads feed a 2-entry skid buffer; Write_FIFO_tvalid is high whenever the buffer is non-empty.
  - Reads are issued only when the buffer has space after the in-flight read. No beat is lost or duplicated under any tready pattern.
  - Data and tvalid stay stable while tvalid=1 and tready=0.
  - Write_FIFO_tlast=1 only with beat BEATS-1.
  - On that beat's handshake: done=1 for one cycle, then IDLE.
- Single-polynomial K=1 is a pass-through of normalised data. In sub mode with K=1 the result is p0.

Decomposition:
- Shared package poly_arith_pkg: Q, CW, the normalise/mod_add/mod_sub functions, and state encoding localparams (IDLE, LOAD, ACC, DRAIN).
- One sub-module: poly_acc_lane. It holds per-lane S2/S3 arithmetic and is instantiated LANES times.
- Accumulator RAM is an inferred simple-dual-port array of BEATS x LANES*CW.

Test Plan:
1. Add, K=1, poly lanes = beat index, one lane = -1 -> output equals the input, with -1 emitted as 8380416; tlast on beat 127 only; done 1 cycle after that handshake.
2. Add, K=3, all coefficients 8380416 -> every output coefficient 8380414.
3. Sub, K=2, p0 all 1, p1 all 2 -> every output 8380416. Sub, K=3, p0=5, p1=2, p2=1 -> every output 2.
4. Add, K=2, Read_FIFO_tvalid and Write_FIFO_tready randomly 50% duty -> 128 output beats, exact values, no drops or duplicates, data stable while stalled.
5. K=2 with tlast asserted at beat 10 of poly 1 -> err=1, still 128 correct output beats; the next start clears err. vec_len=0 -> err=1 and a done pulse with no output.
6. areset asserted during ACC at beat 50 -> next cycle busy=0, tready=0, tvalid=0; a fresh add K=1 run afterwards produces correct output.
